// File: rtl/dev_bus_arbiter_pkg.sv
// rtl/dev_bus_arbiter_pkg.sv - shared state encoding and constants for the two-master device bus arbiter
package dev_bus_arbiter_pkg;

   // Encoding doubles as the one-hot grant vector {m1,m0}
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_OWN0 = 2'b01,
      ST_OWN1 = 2'b10
   } arb_state_t;

   localparam logic        OWNER_CPU    = 1'b0;
   localparam logic        OWNER_DMA    = 1'b1;
   localparam logic [31:0] TIMEOUT_FILL = 32'hFFFF_FFFF;

endpackage

// File: rtl/dev_bus_arbiter.sv
// rtl/dev_bus_arbiter.sv - CPU/DMA device bus arbiter with burst fairness and slave-busy watchdog
module dev_bus_arbiter
   import dev_bus_arbiter_pkg::*;
#(
   parameter int MAX_BURST = 4,
   parameter int TIMEOUT   = 1023
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        m0_enable_i,
   input  logic        m0_write_i,
   input  logic [31:0] m0_addr_i,
   input  logic [31:0] m0_dataSave_i,
   input  logic [3:0]  m0_byteSelect_i,
   output logic        m0_busy_o,
   output logic [31:0] m0_dataLoad_o,
   input  logic        m1_enable_i,
   input  logic        m1_write_i,
   input  logic [31:0] m1_addr_i,
   input  logic [31:0] m1_dataSave_i,
   input  logic [3:0]  m1_byteSelect_i,
   output logic        m1_busy_o,
   output logic [31:0] m1_dataLoad_o,
   output logic        devEnable_o,
   output logic        devWrite_o,
   output logic [31:0] devPhysicalAddr_o,
   output logic [31:0] devDataSave_o,
   output logic [3:0]  devByteSelect_o,
   input  logic        devBusy_i,
   input  logic [31:0] devDataLoad_i,
   output logic [1:0]  grant_o,
   output logic        timeout_o
);

   localparam logic [9:0] WD_LAST   = 10'(TIMEOUT - 1);
   localparam logic [4:0] BURST_LIM = 5'(MAX_BURST);

   arb_state_t  state, next_state, other_state;
   logic        last_owner;
   logic [3:0]  burst_cnt;
   logic [9:0]  wdog;
   logic        owner1, own_en, other_req, tmo, fin, burst_hit;
   logic [31:0] load_val;

   always_comb begin
      owner1      = (state == ST_OWN1);
      own_en      = (state != ST_IDLE) & (owner1 ? m1_enable_i : m0_enable_i);
      other_req   = owner1 ? m0_enable_i : m1_enable_i;
      other_state = owner1 ? ST_OWN0 : ST_OWN1;
      tmo         = own_en & devBusy_i & (wdog == WD_LAST);
      // A watchdog abort ends the access just like a normal completion
      fin         = own_en & (~devBusy_i | tmo);
      burst_hit   = ({1'b0, burst_cnt} + 5'd1) >= BURST_LIM;
      load_val    = tmo ? TIMEOUT_FILL : devDataLoad_i;
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (m0_enable_i && m1_enable_i)
               next_state = (last_owner == OWNER_CPU) ? ST_OWN1 : ST_OWN0;
            else if (m0_enable_i)
               next_state = ST_OWN0;
            else if (m1_enable_i)
               next_state = ST_OWN1;
         end
         ST_OWN0, ST_OWN1: begin
            if (!own_en)
               next_state = other_req ? other_state : ST_IDLE;
            else if (fin && other_req && burst_hit)
               next_state = other_state;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         last_owner <= OWNER_DMA;
         burst_cnt  <= 4'd0;
         wdog       <= 10'd0;
      end else begin
         state <= next_state;
         if (next_state != state) begin
            burst_cnt <= 4'd0;
            wdog      <= 10'd0;
            if (next_state == ST_OWN0)
               last_owner <= OWNER_CPU;
            else if (next_state == ST_OWN1)
               last_owner <= OWNER_DMA;
         end else if (fin) begin
            burst_cnt <= (burst_cnt != 4'hF) ? burst_cnt + 4'd1 : burst_cnt;
            wdog      <= 10'd0;
         end else if (own_en && devBusy_i) begin
            wdog <= wdog + 10'd1;
         end
      end
   end

   always_comb begin
      devEnable_o       = 1'b0;
      devWrite_o        = 1'b0;
      devPhysicalAddr_o = 32'd0;
      devDataSave_o     = 32'd0;
      devByteSelect_o   = 4'd0;
      if (state == ST_OWN0) begin
         devEnable_o       = m0_enable_i;
         devWrite_o        = m0_write_i;
         devPhysicalAddr_o = m0_addr_i;
         devDataSave_o     = m0_dataSave_i;
         devByteSelect_o   = m0_byteSelect_i;
      end else if (state == ST_OWN1) begin
         devEnable_o       = m1_enable_i;
         devWrite_o        = m1_write_i;
         devPhysicalAddr_o = m1_addr_i;
         devDataSave_o     = m1_dataSave_i;
         devByteSelect_o   = m1_byteSelect_i;
      end
   end

   assign m0_busy_o     = m0_enable_i & ~((state == ST_OWN0) & fin);
   assign m1_busy_o     = m1_enable_i & ~((state == ST_OWN1) & fin);
   assign m0_dataLoad_o = ((state == ST_OWN0) & fin) ? load_val : 32'd0;
   assign m1_dataLoad_o = ((state == ST_OWN1) & fin) ? load_val : 32'd0;
   assign grant_o       = state;
   assign timeout_o     = tmo;

endmodule

// File: tb/tb_dev_bus_arbiter.sv
// tb/tb_dev_bus_arbiter.sv - directed self-checking bench for dev_bus_arbiter
module tb_dev_bus_arbiter;

   logic        clk, rst_n;
   logic        m0_enable_i, m0_write_i, m1_enable_i, m1_write_i;
   logic [31:0] m0_addr_i, m0_dataSave_i, m1_addr_i, m1_dataSave_i;
   logic [3:0]  m0_byteSelect_i, m1_byteSelect_i;
   logic        m0_busy_o, m1_busy_o;
   logic [31:0] m0_dataLoad_o, m1_dataLoad_o;
   logic        devEnable_o, devWrite_o;
   logic [31:0] devPhysicalAddr_o, devDataSave_o;
   logic [3:0]  devByteSelect_o;
   logic        devBusy_i;
   logic [31:0] devDataLoad_i;
   logic [1:0]  grant_o;
   logic        timeout_o;

   int tests = 0;
   int fails = 0;

   dev_bus_arbiter #(.MAX_BURST(4), .TIMEOUT(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_enable_i(m0_enable_i), .m0_write_i(m0_write_i), .m0_addr_i(m0_addr_i),
      .m0_dataSave_i(m0_dataSave_i), .m0_byteSelect_i(m0_byteSelect_i),
      .m0_busy_o(m0_busy_o), .m0_dataLoad_o(m0_dataLoad_o),
      .m1_enable_i(m1_enable_i), .m1_write_i(m1_write_i), .m1_addr_i(m1_addr_i),
      .m1_dataSave_i(m1_dataSave_i), .m1_byteSelect_i(m1_byteSelect_i),
      .m1_busy_o(m1_busy_o), .m1_dataLoad_o(m1_dataLoad_o),
      .devEnable_o(devEnable_o), .devWrite_o(devWrite_o),
      .devPhysicalAddr_o(devPhysicalAddr_o), .devDataSave_o(devDataSave_o),
      .devByteSelect_o(devByteSelect_o), .devBusy_i(devBusy_i),
      .devDataLoad_i(devDataLoad_i), .grant_o(grant_o), .timeout_o(timeout_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      m0_enable_i = 0; m0_write_i = 0; m0_addr_i = 0; m0_dataSave_i = 0; m0_byteSelect_i = 0;
      m1_enable_i = 0; m1_write_i = 0; m1_addr_i = 0; m1_dataSave_i = 0; m1_byteSelect_i = 0;
      devBusy_i = 0; devDataLoad_i = 0;
      cyc(); cyc();
      tests++; if (grant_o !== 2'b00) begin fails++; $display("FAIL reset_grant got=%b exp=00", grant_o); end
      tests++; if (timeout_o !== 1'b0) begin fails++; $display("FAIL reset_timeout got=%b exp=0", timeout_o); end
      tests++; if (devEnable_o !== 1'b0) begin fails++; $display("FAIL reset_dev_en got=%b exp=0", devEnable_o); end
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_single_read();
      m0_enable_i = 1; m0_write_i = 0; m0_addr_i = 32'h8000_0000; m0_byteSelect_i = 4'hF;
      devBusy_i = 0; devDataLoad_i = 32'hA5A5_0001;
      #1;
      tests++; if (m0_busy_o !== 1'b1 || grant_o !== 2'b00 || devEnable_o !== 1'b0) begin
         fails++; $display("FAIL read_req_cycle busy=%b grant=%b dev_en=%b exp 1/00/0", m0_busy_o, grant_o, devEnable_o); end
      cyc();
      tests++; if (grant_o !== 2'b01) begin fails++; $display("FAIL read_grant got=%b exp=01", grant_o); end
      tests++; if (m0_busy_o !== 1'b0) begin fails++; $display("FAIL read_busy got=%b exp=0", m0_busy_o); end
      tests++; if (m0_dataLoad_o !== 32'hA5A5_0001) begin fails++; $display("FAIL read_data got=%h exp=a5a50001", m0_dataLoad_o); end
      tests++; if (devPhysicalAddr_o !== 32'h8000_0000 || devEnable_o !== 1'b1 || devByteSelect_o !== 4'hF) begin
         fails++; $display("FAIL read_dev_mirror addr=%h en=%b bs=%h exp 80000000/1/f", devPhysicalAddr_o, devEnable_o, devByteSelect_o); end
      m0_enable_i = 0;
      cyc();
      tests++; if (grant_o !== 2'b00) begin fails++; $display("FAIL read_back_idle got=%b exp=00", grant_o); end
   endtask

   task automatic test_tie();
      rst_n = 1'b0; #1; rst_n = 1'b1;
      cyc();
      m0_enable_i = 1; m1_enable_i = 1; devBusy_i = 0; devDataLoad_i = 32'h0000_1234;
      cyc();
      tests++; if (grant_o !== 2'b01 || m0_busy_o !== 1'b0 || m1_busy_o !== 1'b1) begin
         fails++; $display("FAIL tie_first grant=%b m0_busy=%b m1_busy=%b exp 01/0/1", grant_o, m0_busy_o, m1_busy_o); end
      m0_enable_i = 0;
      cyc();
      tests++; if (grant_o !== 2'b10) begin fails++; $display("FAIL tie_handover got=%b exp=10", grant_o); end
      tests++; if (m1_busy_o !== 1'b0 || m1_dataLoad_o !== 32'h0000_1234 || m0_dataLoad_o !== 32'd0) begin
         fails++; $display("FAIL tie_m1_done busy=%b d1=%h d0=%h exp 0/00001234/0", m1_busy_o, m1_dataLoad_o, m0_dataLoad_o); end
      m1_enable_i = 0;
      cyc();
      tests++; if (grant_o !== 2'b00) begin fails++; $display("FAIL tie_idle got=%b exp=00", grant_o); end
   endtask

   task automatic test_burst();
      int cnt = 0;
      int bad = 0;
      bit switched = 0;
      m0_enable_i = 1; m1_enable_i = 1; devBusy_i = 0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         if (grant_o === 2'b10) begin switched = 1; break; end
         if (grant_o === 2'b01) begin
            if (m0_busy_o === 1'b0) cnt++;
            if (m1_busy_o !== 1'b1) bad++;
         end
      end
      tests++; if (cnt != 4) begin fails++; $display("FAIL burst_count got=%0d exp=4", cnt); end
      tests++; if (!switched) begin fails++; $display("FAIL burst_switch got=%b exp=10", grant_o); end
      tests++; if (bad != 0) begin fails++; $display("FAIL burst_m1_wait_busy drops=%0d exp=0", bad); end
      m0_enable_i = 0; m1_enable_i = 0;
      cyc();
      tests++; if (grant_o !== 2'b00) begin fails++; $display("FAIL burst_idle got=%b exp=00", grant_o); end
   endtask

   task automatic test_timeout();
      int first = 0;
      int pulses = 0;
      m0_enable_i = 1; devBusy_i = 1;
      for (int n = 1; n <= 12; n++) begin
         cyc();
         if (n == 7) begin
            tests++; if (timeout_o !== 1'b0 || m0_busy_o !== 1'b1) begin
               fails++; $display("FAIL timeout_early tmo=%b busy=%b exp 0/1", timeout_o, m0_busy_o); end
         end
         if (timeout_o === 1'b1) begin
            pulses++;
            if (first == 0) begin
               first = n;
               tests++; if (m0_busy_o !== 1'b0 || m0_dataLoad_o !== 32'hFFFF_FFFF) begin
                  fails++; $display("FAIL timeout_resp busy=%b data=%h exp 0/ffffffff", m0_busy_o, m0_dataLoad_o); end
            end
         end
      end
      tests++; if (first != 8) begin fails++; $display("FAIL timeout_cycle got=%0d exp=8", first); end
      tests++; if (pulses != 1) begin fails++; $display("FAIL timeout_pulses got=%0d exp=1", pulses); end
      m0_enable_i = 0; devBusy_i = 0;
      cyc();
   endtask

   task automatic test_reset_mid();
      m1_enable_i = 1; m1_write_i = 1; m1_addr_i = 32'h0000_0040; devBusy_i = 1;
      cyc();
      tests++; if (grant_o !== 2'b10 || devEnable_o !== 1'b1 || devWrite_o !== 1'b1) begin
         fails++; $display("FAIL rmid_own grant=%b en=%b wr=%b exp 10/1/1", grant_o, devEnable_o, devWrite_o); end
      rst_n = 1'b0;
      #1;
      tests++; if (devEnable_o !== 1'b0 || grant_o !== 2'b00) begin
         fails++; $display("FAIL rmid_async en=%b grant=%b exp 0/00", devEnable_o, grant_o); end
      tests++; if (m1_busy_o !== 1'b1 || m1_dataLoad_o !== 32'd0 || timeout_o !== 1'b0) begin
         fails++; $display("FAIL rmid_no_cplt busy=%b data=%h tmo=%b exp 1/0/0", m1_busy_o, m1_dataLoad_o, timeout_o); end
      cyc();
      rst_n = 1'b1; m0_enable_i = 1; devBusy_i = 0;
      cyc();
      tests++; if (grant_o !== 2'b01) begin fails++; $display("FAIL rmid_tie got=%b exp=01", grant_o); end
      m0_enable_i = 0; m1_enable_i = 0; m1_write_i = 0;
      cyc();
   endtask

   task automatic test_drop();
      int cnt = 0;
      m0_enable_i = 1; m1_enable_i = 1; devBusy_i = 0; devDataLoad_i = 32'h0BAD_F00D;
      cyc();
      tests++; if (grant_o !== 2'b10 || m1_dataLoad_o !== 32'h0BAD_F00D) begin
         fails++; $display("FAIL drop_m1_first grant=%b data=%h exp 10/0badf00d", grant_o, m1_dataLoad_o); end
      m1_enable_i = 0; devBusy_i = 1;
      #1;
      tests++; if (m1_busy_o !== 1'b0 || m1_dataLoad_o !== 32'd0 || m0_busy_o !== 1'b1 || devEnable_o !== 1'b0) begin
         fails++; $display("FAIL drop_no_data busy1=%b d1=%h busy0=%b en=%b exp 0/0/1/0", m1_busy_o, m1_dataLoad_o, m0_busy_o, devEnable_o); end
      cyc();
      m1_enable_i = 1; devBusy_i = 0;
      #1;
      tests++; if (grant_o !== 2'b01) begin fails++; $display("FAIL drop_handover got=%b exp=01", grant_o); end
      for (int i = 0; i < 10; i++) begin
         if (grant_o === 2'b10) break;
         if (grant_o === 2'b01 && m0_busy_o === 1'b0) cnt++;
         cyc();
      end
      tests++; if (cnt != 4 || grant_o !== 2'b10) begin
         fails++; $display("FAIL drop_burst_cleared cnt=%0d grant=%b exp 4/10", cnt, grant_o); end
      m0_enable_i = 0; m1_enable_i = 0;
      cyc();
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_tie();
      test_burst();
      test_timeout();
      test_reset_mid();
      test_drop();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/dev_bus_arbiter.md
DEV_BUS_ARBITER -- requirements
Module: dev_bus_arbiter

Interface
REQ-001 MAX_BURST, 4, max consecutive completions by one master while the other waits; legal range 1..15.
REQ-002 TIMEOUT, 1023, slave-busy cycles before a transaction is aborted; legal range 2..1023 (10-bit counter).
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 mN_enable_i (N=0 CPU, N=1 DMA)  in  1  request; held high until completion.
REQ-006 mN_write_i  in  1  1=write, 0=read.
REQ-007 mN_addr_i  in  32  physical address.
REQ-008 mN_dataSave_i  in  32  write data.
REQ-009 mN_byteSelect_i  in  4  byte lanes.
REQ-010 mN_busy_o  out  1  high while the request is pending.
REQ-011 mN_dataLoad_o  out  32  read data, valid in the completion cycle.
REQ-012 devEnable_o, devWrite_o  out  1  shared device bus strobes.
REQ-013 devPhysicalAddr_o, devDataSave_o  out  32; devByteSelect_o  out  4.
REQ-014 devBusy_i  in  1; devDataLoad_i  in  32  slave response.
REQ-015 grant_o  out  2  one-hot owner {m1,m0}; timeout_o  out  1  one-cycle abort pulse.

Function
REQ-016 Registered FSM states: IDLE, OWN0, OWN1; grant_o SHALL be 00/01/10 respectively.
REQ-017 IDLE: no request -> stay; one request -> own that master next cycle; both -> master != lastOwner.
REQ-018 In OWNn, dev* outputs SHALL combinationally mirror mN inputs (devEnable_o = mN_enable_i); in IDLE all dev* outputs SHALL be 0.
REQ-019 Completion = cycle in OWNn with mN_enable_i=1 and devBusy_i=0; mN_busy_o=0 and mN_dataLoad_o=devDataLoad_i in that cycle.
REQ-020 mN_busy_o SHALL equal mN_enable_i except in mN's completion cycle; non-owner mN_dataLoad_o SHALL be 0.
REQ-021 Minimum latency from IDLE: request cycle busy=1, earliest completion next cycle.
REQ-022 burstCnt (4-bit) SHALL increment per completion of the owner and clear on ownership change.
REQ-023 After completion: if other master requests and burstCnt+1 >= MAX_BURST -> own other; else stay (owner remains in state; REQ-024 handles owner enable low).
REQ-024 Owner enable low in OWNn (with or without completion): next state = other master if requesting, else IDLE; no burst count.
REQ-025 Ownership changes SHALL go directly OWN0<->OWN1 without an IDLE cycle; lastOwner updated on every grant.
REQ-026 Watchdog counter SHALL count OWNn cycles with enable=1, devBusy_i=1; clear on completion or ownership change.
REQ-027 When watchdog reaches TIMEOUT-1 and devBusy_i=1: that cycle mN_busy_o=0, mN_dataLoad_o=32'hFFFFFFFF, timeout_o=1; treated as a completion for REQ-023.
REQ-028 Simultaneous completion and new request from the other master SHALL follow REQ-023 in the same edge; no request SHALL be lost.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, lastOwner=1 (m0 wins first tie), burstCnt=0, watchdog=0, grant_o=00, timeout_o=0, dev* outputs 0.
REQ-030 Reset mid-transaction SHALL drop devEnable_o asynchronously; no completion SHALL be reported for the aborted access.

Structure
REQ-031 Shared package SHALL hold the state encoding, owner index constants (OWNER_CPU=0, OWNER_DMA=1) and the timeout fill value 32'hFFFFFFFF.
REQ-032 Single module; no sub-module (watchdog and burst counter inline).

Verification
REQ-033 m0 read, addr 32'h80000000, devBusy_i low -> grant_o=01 next cycle, m0_busy_o low that cycle, m0_dataLoad_o=devDataLoad_i.
REQ-034 Both request in IDLE after reset -> m0 granted first; after m0 completion with m0 dropping enable, OWN1 next cycle.
REQ-035 MAX_BURST=4, m0 continuous, m1 waiting -> exactly 4 m0 completions, then grant_o=10; m1_busy_o high throughout wait.
REQ-036 TIMEOUT=8, devBusy_i stuck high -> after 8 owned cycles timeout_o pulses once, busy_o low, dataLoad_o=32'hFFFFFFFF.
REQ-037 rst_n asserted mid m1 write -> devEnable_o low same cycle, grant_o=00, no completion; after release m0 wins tie.
REQ-038 m1 owner drops enable before completion while m0 requests -> OWN0 next cycle, burstCnt=0, no data returned to m1.
